fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main/ALU decoder.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Holds each fetched instruction in an instruction register that drives op/funct/immediate fields to decode.
- On retirement of each instruction, computes the next PC from the decoder/datapath branch, bne and jump signals plus the ALU zero flag.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_nextpc.sv | 40 ++++
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, reset PC,
// and the opcode constants the decoder agrees on.
package fetch_pkg;

    localparam int          FETCH_WIDTH      = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/fetch_nextpc.sv
// Next-PC computation: sequential, conditional branch (beq/bne) and jump targets.
module fetch_nextpc
    import fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        bne,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pcplus4,
    output logic [31:0] next_pc
);

    logic [31:0] signimm_s;
    logic [31:0] btarget_s;
    logic [31:0] jtarget_s;
    logic        taken_s;
    logic        unused_op_s;

    // Opcode is decoded upstream; this block only consumes decoder controls.
    assign unused_op_s = ^instr[31:26];

    // Target selection; jump wins over any branch asserted alongside it.
    always_comb begin
        pcplus4   = pc + 32'd4;
        signimm_s = sign_ext16(instr[15:0]);
        btarget_s = pcplus4 + {signimm_s[29:0], 2'b00};
        jtarget_s = {pcplus4[31:28], instr[25:0], 2'b00};
        taken_s   = (branch & zero) | (bne & ~zero);
        if (jump) begin
            next_pc = jtarget_s;
        end else if (taken_s) begin
            next_pc = btarget_s;
        end else begin
            next_pc = pcplus4;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handshakes with a variable-latency
// instruction memory and presents one instruction at a time to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          WIDTH    = FETCH_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pcplus4,
    input  logic             branch,
    input  logic             bne,
    input  logic             jump,
    input  logic             zero,
    output logic [WIDTH-1:0] retired_count
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] next_pc_s;

    fetch_nextpc u_nextpc (
        .pc      (pc_q),
        .instr   (instr_q),
        .branch  (branch),
        .bne     (bne),
        .jump    (jump),
        .zero    (zero),
        .pcplus4 (pcplus4),
        .next_pc (next_pc_s)
    );

    // State and datapath registers; reset discards any in-flight instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_START;
            pc_q      <= RESET_PC_ALIGNED;
            instr_q   <= 32'h0000_0000;
            retired_q <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    // Next state; controls and memory data are only looked at in the one
    // state where they matter, so X elsewhere never reaches a register.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            ST_START: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (instr_ready) begin
                    pc_d      = next_pc_s;
                    retired_d = retired_q + 32'd1;
                    state_d   = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            ST_FETCH: imem_req    = 1'b1;
            ST_HOLD:  instr_valid = 1'b1;
            default: begin
                imem_req    = 1'b0;
                instr_valid = 1'b0;
            end
        endcase
    end

    assign imem_addr     = pc_q;
    assign pc            = pc_q;
    assign instr         = instr_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup, latency variation, branch/jump
// target selection, back-pressure and reset during a fetch.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        branch;
    logic        bne;
    logic        jump;
    logic        zero;
    logic [31:0] retired_count;

    int          checks    = 0;
    int          errors    = 0;
    logic [31:0] exp_count = 32'd0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .pcplus4       (pcplus4),
        .branch        (branch),
        .bne           (bne),
        .jump          (jump),
        .zero          (zero),
        .retired_count (retired_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Entry and exit: 1 time unit after a rising edge with the DUT in FETCH.
    task automatic fetch_retire(input int lat, input int stall, input logic [31:0] rdata,
                                input logic [31:0] addr, input logic [31:0] next_addr,
                                input logic br, input logic bn, input logic jp, input logic z);
        for (int i = 0; i < lat; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, addr);
            chk("wait_valid", {31'd0, instr_valid}, 32'd0);
            @(posedge clk); #1;
        end
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(negedge clk);
        chk("ack_req", {31'd0, imem_req}, 32'd1);
        chk("ack_addr", imem_addr, addr);
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_instr", instr, rdata);
        chk("hold_pc", pc, addr);
        chk("hold_pcplus4", pcplus4, addr + 32'd4);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            imem_ack   = i[0];
            imem_rdata = $urandom;
            @(negedge clk);
            chk("bp_instr", instr, rdata);
            chk("bp_pc", pc, addr);
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_req", {31'd0, imem_req}, 32'd0);
            chk("bp_count", retired_count, exp_count);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        branch      = br;
        bne         = bn;
        jump        = jp;
        zero        = z;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        branch      = 1'bx;
        bne         = 1'bx;
        jump        = 1'bx;
        zero        = 1'bx;
        exp_count   = exp_count + 32'd1;
        chk("next_addr", imem_addr, next_addr);
        chk("next_req", {31'd0, imem_req}, 32'd1);
        chk("retired", retired_count, exp_count);
        chk("next_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0000_0000;
        instr_ready = 1'b0;
        branch      = 1'b0;
        bne         = 1'b0;
        jump        = 1'b0;
        zero        = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_count", retired_count, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("start_req", {31'd0, imem_req}, 32'd0);
        chk("start_valid", {31'd0, instr_valid}, 32'd0);
        @(posedge clk); #1;

        // Sequential fetch with ack latencies 0, 1, 3; third is a taken beq.
        fetch_retire(0, 0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch_retire(1, 0, 32'h8C01_0004, 32'h0000_0004, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch_retire(3, 0, 32'h1000_0003, 32'h0000_0008, 32'h0000_0018, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("count_three", retired_count, 32'd3);
        // Jump back to 0x8 and exercise beq not-taken and both bne outcomes.
        fetch_retire(0, 0, 32'h0800_0002, 32'h0000_0018, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch_retire(2, 0, 32'h1000_0003, 32'h0000_0008, 32'h0000_000C, 1'b1, 1'b0, 1'b0, 1'b0);
        fetch_retire(0, 0, 32'h0800_0002, 32'h0000_000C, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch_retire(0, 0, 32'h1400_0003, 32'h0000_0008, 32'h0000_000C, 1'b0, 1'b1, 1'b0, 1'b1);
        fetch_retire(1, 0, 32'h0800_0002, 32'h0000_000C, 32'h0000_0008, 1'b0, 1'b0, 1'b1, 1'b0);
        fetch_retire(0, 0, 32'h1400_0003, 32'h0000_0008, 32'h0000_0018, 1'b0, 1'b1, 1'b0, 1'b0);
        // Jump with a taken beq asserted alongside: jump target wins.
        fetch_retire(0, 0, 32'h0800_0010, 32'h0000_0018, 32'h0000_0040, 1'b1, 1'b0, 1'b1, 1'b1);
        // Negative offset: 0x44 + (-16 << 2) = 0x4.
        fetch_retire(0, 0, 32'h1000_FFF0, 32'h0000_0040, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b1);
        // Back-pressure for 5 cycles with ack/rdata toggling underneath.
        fetch_retire(0, 5, 32'hAC22_0008, 32'h0000_0004, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b0);
        fetch_retire(1, 0, 32'h1000_0005, 32'h0000_0008, 32'h0000_0020, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset lands mid-FETCH at 0x20 while an ack is on the bus.
        chk("pre_rst_addr", imem_addr, 32'h0000_0020);
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_instr", instr, 32'h0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_count", retired_count, 32'h0);
        @(posedge clk); #1;
        chk("rst_ack_ignored", instr, 32'h0);
        chk("rst_valid_low", {31'd0, instr_valid}, 32'd0);
        reset      = 1'b1;
        imem_ack   = 1'b0;
        exp_count  = 32'd0;
        @(negedge clk);
        chk("restart_idle", {31'd0, imem_req}, 32'd0);
        @(posedge clk); #1;
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_count", retired_count, 32'h0);
        fetch_retire(0, 0, 32'h0000_0020, 32'h0000_0000, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
